dds_sweep_ctrl: RTL

- Sequencer that drives the control inputs of one DDS instance: ce, rst, tuning_word and start_phase.
- Produces frequency sweeps: stepped chirps from a start tuning word to a stop tuning word, with a programmable dwell per step.
- Sweep modes: single-shot, repeat, or ping-pong.
- Sits between the register/config block and the DDS; the DDS output path is untouched.

---
 rtl/dds_sweep_ctrl_if.sv | 47 ++++
 rtl/dds_sweep_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl_if.sv
// Interface bundling the sweep controller's command, configuration and DDS-side signals.
//   master : config/register side (drives start, abort, cfg_*, observes status)
//   slave  : dds_sweep_ctrl itself (consumes cfg, drives DDS controls and status)
// Signals:
//   start, abort             sweep commands
//   cfg_f_start/stop/step    tuning word start, limit and increment (TW bits)
//   cfg_dwell                cycles per step (CW bits, 0 acts as 1)
//   cfg_mode                 0 single, 1 repeat, 2 ping-pong, 3 single
//   cfg_phase                DDS start phase (PW bits)
//   dds_ce, dds_rst          DDS clock enable and load pulse
//   dds_tuning_word          DDS tuning word
//   dds_start_phase          DDS start phase
//   busy, done, sweep_cnt    status
interface dds_sweep_ctrl_if #(
  parameter int unsigned TW = 10,
  parameter int unsigned PW = 15,
  parameter int unsigned CW = 16
) ();

  logic          start;
  logic          abort;
  logic [TW-1:0] cfg_f_start;
  logic [TW-1:0] cfg_f_stop;
  logic [TW-1:0] cfg_f_step;
  logic [CW-1:0] cfg_dwell;
  logic [1:0]    cfg_mode;
  logic [PW-1:0] cfg_phase;

  logic          dds_ce;
  logic          dds_rst;
  logic [TW-1:0] dds_tuning_word;
  logic [PW-1:0] dds_start_phase;
  logic          busy;
  logic          done;
  logic [15:0]   sweep_cnt;

  modport master (
    output start, abort, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell, cfg_mode, cfg_phase,
    input  dds_ce, dds_rst, dds_tuning_word, dds_start_phase, busy, done, sweep_cnt
  );

  modport slave (
    input  start, abort, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell, cfg_mode, cfg_phase,
    output dds_ce, dds_rst, dds_tuning_word, dds_start_phase, busy, done, sweep_cnt
  );

endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep sequencer for a single DDS instance. Produces stepped chirps from a start
// tuning word up to a stop limit with a programmable dwell per step, in single-shot, repeat
// or ping-pong mode. All outputs are registered.
// Ports:
//   clk   system clock
//   rstn  synchronous active-low reset
//   bus   dds_sweep_ctrl_if.slave: commands/config in, DDS controls and status out
module dds_sweep_ctrl #(
  parameter int unsigned TW = 10,
  parameter int unsigned PW = 15,
  parameter int unsigned CW = 16
) (
  input logic             clk,
  input logic             rstn,
  dds_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  localparam logic [1:0] ModeRepeat   = 2'd1;
  localparam logic [1:0] ModePingpong = 2'd2;

  state_e        state_q;
  logic [TW-1:0] tw_q;
  logic [TW-1:0] f_start_q;
  logic [TW-1:0] f_stop_q;
  logic [TW-1:0] f_step_q;
  logic [CW-1:0] dwell_m1_q;
  logic [CW-1:0] dwell_cnt_q;
  logic [1:0]    mode_q;
  logic          dir_down_q;

  logic          ce_q;
  logic          rst_q;
  logic          busy_q;
  logic          done_q;
  logic [PW-1:0] phase_q;
  logic [15:0]   sweep_cnt_q;

  // Step arithmetic is one bit wider so a carry (up) or borrow (down) is visible.
  logic [TW:0]   nxt_up;
  logic [TW:0]   nxt_dn;
  logic          overshoot;
  logic          undershoot;
  logic          dwell_end;
  logic [CW-1:0] cfg_dwell_m1;

  always_comb begin
    nxt_up       = {1'b0, tw_q} + {1'b0, f_step_q};
    nxt_dn       = {1'b0, tw_q} - {1'b0, f_step_q};
    overshoot    = nxt_up > {1'b0, f_stop_q};
    undershoot   = nxt_dn[TW] | (nxt_dn[TW-1:0] < f_start_q);
    dwell_end    = dwell_cnt_q == dwell_m1_q;
    // A dwell of 0 behaves as 1.
    cfg_dwell_m1 = (bus.cfg_dwell == '0) ? '0 : bus.cfg_dwell - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      tw_q        <= '0;
      f_start_q   <= '0;
      f_stop_q    <= '0;
      f_step_q    <= '0;
      dwell_m1_q  <= '0;
      dwell_cnt_q <= '0;
      mode_q      <= '0;
      dir_down_q  <= 1'b0;
      ce_q        <= 1'b0;
      rst_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      phase_q     <= '0;
      sweep_cnt_q <= '0;
    end else begin
      rst_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start && !bus.abort) begin
            f_start_q   <= bus.cfg_f_start;
            f_stop_q    <= bus.cfg_f_stop;
            f_step_q    <= bus.cfg_f_step;
            dwell_m1_q  <= cfg_dwell_m1;
            mode_q      <= bus.cfg_mode;
            phase_q     <= bus.cfg_phase;
            tw_q        <= bus.cfg_f_start;
            dir_down_q  <= 1'b0;
            dwell_cnt_q <= '0;
            rst_q       <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StLoad;
          end
        end
        StLoad: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            ce_q    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (bus.abort) begin
            ce_q        <= 1'b0;
            busy_q      <= 1'b0;
            dwell_cnt_q <= '0;
            state_q     <= StIdle;
          end else if (!dwell_end) begin
            dwell_cnt_q <= dwell_cnt_q + CW'(1);
          end else begin
            dwell_cnt_q <= '0;
            if (!dir_down_q) begin
              if (!overshoot) begin
                tw_q <= nxt_up[TW-1:0];
              end else begin
                sweep_cnt_q <= sweep_cnt_q + 16'd1;
                if (mode_q == ModePingpong) begin
                  // Turn around; the top value dwells a second time.
                  dir_down_q <= 1'b1;
                end else if (mode_q == ModeRepeat) begin
                  // No DDS reload, so phase stays continuous across the wrap.
                  tw_q <= f_start_q;
                end else begin
                  ce_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
                end
              end
            end else begin
              if (!undershoot) begin
                tw_q <= nxt_dn[TW-1:0];
              end else begin
                sweep_cnt_q <= sweep_cnt_q + 16'd1;
                dir_down_q  <= 1'b0;
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.dds_ce          = ce_q;
  assign bus.dds_rst         = rst_q;
  assign bus.dds_tuning_word = tw_q;
  assign bus.dds_start_phase = phase_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.sweep_cnt       = sweep_cnt_q;

endmodule
